// File: rtl/phase_sequencer.sv
// Multi-phase clock-enable sequencer: NUM_PHASES phases of DIV clocks each, NUM_CH phase-window outputs.
// Optional macro PHASE_SEQ_STALL_EN enables the memory-wait stall input; otherwise stall is ignored.
module phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int NUM_CH     = 2,
    parameter int DIV        = 1,
    localparam int PW        = $clog2(NUM_PHASES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step,
    input  logic                 stall,
    input  logic [NUM_CH*PW-1:0] rise_phase,
    input  logic [NUM_CH*PW-1:0] fall_phase,
    output logic [NUM_CH-1:0]    ch_out,
    output logic [PW-1:0]        phase,
    output logic                 cycle_start,
    output logic                 cycle_done,
    output logic                 busy
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(NUM_PHASES - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);

`ifdef PHASE_SEQ_STALL_EN
    localparam logic STALL_EN = 1'b1;
`else
    localparam logic STALL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [DW-1:0]         div_q, div_d;
    logic [NUM_CH-1:0]     ch_q, ch_d;
    logic [NUM_CH*PW-1:0]  rise_q, rise_d, fall_q, fall_d;
    logic                  start_q, start_d;
    logic                  stall_eff;
    logic                  load_win;

    assign stall_eff = stall & STALL_EN;

    // Circular window [rise, fall); degenerate or out-of-range windows stay low.
    function automatic logic [NUM_CH-1:0] window_bits(input logic [NUM_CH*PW-1:0] rise,
                                                      input logic [NUM_CH*PW-1:0] fall,
                                                      input logic [PW-1:0]        p);
        int r_i;
        int f_i;
        int p_i;
        window_bits = '0;
        p_i = int'(p);
        for (int i = 0; i < NUM_CH; i++) begin
            r_i = int'(rise[i*PW +: PW]);
            f_i = int'(fall[i*PW +: PW]);
            if (r_i >= NUM_PHASES || f_i >= NUM_PHASES || r_i == f_i)
                window_bits[i] = 1'b0;
            else if (r_i < f_i)
                window_bits[i] = (p_i >= r_i) && (p_i < f_i);
            else
                window_bits[i] = (p_i >= r_i) || (p_i < f_i);
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        div_d    = div_q;
        ch_d     = ch_q;
        rise_d   = rise_q;
        fall_d   = fall_q;
        start_d  = 1'b0;
        load_win = 1'b0;
        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                div_d   = '0;
                ch_d    = '0;
                if (run) begin
                    state_d  = S_RUN;
                    start_d  = 1'b1;
                    load_win = 1'b1;
                end else if (step) begin
                    state_d  = S_STEP;
                    start_d  = 1'b1;
                    load_win = 1'b1;
                end
            end
            default: begin
                if (!stall_eff) begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (phase_q == PHASE_LAST) begin
                            // Wrap: only a RUN cycle with run still high continues.
                            phase_d = '0;
                            if (state_q == S_RUN && run) begin
                                start_d  = 1'b1;
                                load_win = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                                ch_d    = '0;
                            end
                        end else begin
                            phase_d = phase_q + PW'(1);
                            ch_d    = window_bits(rise_q, fall_q, phase_d);
                        end
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
            end
        endcase
        if (load_win) begin
            rise_d = rise_phase;
            fall_d = fall_phase;
            ch_d   = window_bits(rise_phase, fall_phase, '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            div_q   <= '0;
            ch_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            div_q   <= div_d;
            ch_q    <= ch_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            start_q <= start_d;
        end
    end

    assign ch_out      = ch_q;
    assign phase       = phase_q;
    assign cycle_start = start_q;
    assign busy        = (state_q != S_IDLE);
    assign cycle_done  = (state_q != S_IDLE) && (phase_q == PHASE_LAST) &&
                         (div_q == DIV_LAST) && !stall_eff;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: default build, a DIV=3 instance and a 6-phase instance.
module tb_phase_sequencer;

`ifdef PHASE_SEQ_STALL_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       run;
    logic       step;
    logic       stall;

    logic [3:0] rise_a, fall_a;
    logic [1:0] ch_a, phase_a;
    logic       start_a, done_a, busy_a;

    logic [1:0] rise_b, fall_b;
    logic [0:0] ch_b;
    logic [1:0] phase_b;
    logic       start_b, done_b, busy_b;

    logic [2:0] rise_c, fall_c;
    logic [0:0] ch_c;
    logic [2:0] phase_c;
    logic       start_c, done_c, busy_c;

    int errors = 0;
    int checks = 0;
    logic [5:0] exp_q[$];

    phase_sequencer #(.NUM_PHASES(4), .NUM_CH(2), .DIV(1)) dut_a (
        .clk(clk), .reset(reset), .run(run), .step(step), .stall(stall),
        .rise_phase(rise_a), .fall_phase(fall_a), .ch_out(ch_a), .phase(phase_a),
        .cycle_start(start_a), .cycle_done(done_a), .busy(busy_a)
    );

    phase_sequencer #(.NUM_PHASES(4), .NUM_CH(1), .DIV(3)) dut_b (
        .clk(clk), .reset(reset), .run(run), .step(step), .stall(stall),
        .rise_phase(rise_b), .fall_phase(fall_b), .ch_out(ch_b), .phase(phase_b),
        .cycle_start(start_b), .cycle_done(done_b), .busy(busy_b)
    );

    phase_sequencer #(.NUM_PHASES(6), .NUM_CH(1), .DIV(1)) dut_c (
        .clk(clk), .reset(reset), .run(run), .step(step), .stall(stall),
        .rise_phase(rise_c), .fall_phase(fall_c), .ch_out(ch_c), .phase(phase_c),
        .cycle_start(start_c), .cycle_done(done_c), .busy(busy_c)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic       step;
        logic [1:0] phase;
        logic [1:0] ch;
        logic       start;
        logic       done;
        logic       busy;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        run   = 1'b0;
        step  = 1'b0;
        stall = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic legacy_windows();
        rise_a = {2'd1, 2'd0};
        fall_a = {2'd2, 2'd3};
    endtask

    initial begin
        logic [3:0] old_w;
        logic [3:0] new_w;
        logic [3:0] ch0_pat;
        logic [1:0] legacy_ch[4];
        logic [5:0] exp_v;
        int         ph;
        logic       st;

        legacy_ch[0] = 2'b01;
        legacy_ch[1] = 2'b11;
        legacy_ch[2] = 2'b01;
        legacy_ch[3] = 2'b00;

        //              run step ph  ch    st done busy
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 2'b01, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 2'd1, 2'b11, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 2'd2, 2'b01, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 2'd3, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 2'b01, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 2'd1, 2'b11, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 2'd2, 2'b01, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 2'd3, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'd0, 2'b01, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 2'd1, 2'b11, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 2'd2, 2'b01, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 2'd3, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 2'd0, 2'b01, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 2'd1, 2'b11, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 2'd2, 2'b01, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 2'd3, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 2'd0, 2'b01, 1'b1, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 2'd1, 2'b11, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 2'd2, 2'b01, 1'b0, 1'b0, 1'b1};
        vecs[21] = '{1'b0, 1'b0, 2'd3, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[22] = '{1'b0, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0};

        rise_b = 2'd0;
        fall_b = 2'd2;
        rise_c = 3'd0;
        fall_c = 3'd0;
        legacy_windows();

        // reset state
        apply_reset();
        check("reset phase", phase_a, 0);
        check("reset ch_out", ch_a, 0);
        check("reset cycle_start", start_a, 0);
        check("reset cycle_done", done_a, 0);
        check("reset busy", busy_a, 0);
        check("reset busy div3", busy_b, 0);
        check("reset busy np6", busy_c, 0);

        // legacy pattern, step, run priority
        for (int i = 0; i < 23; i++) begin
            run  = vecs[i].run;
            step = vecs[i].step;
            tick();
            check($sformatf("vec%0d phase", i), phase_a, vecs[i].phase);
            check($sformatf("vec%0d ch_out", i), ch_a, vecs[i].ch);
            check($sformatf("vec%0d cycle_start", i), start_a, vecs[i].start);
            check($sformatf("vec%0d cycle_done", i), done_a, vecs[i].done);
            check($sformatf("vec%0d busy", i), busy_a, vecs[i].busy);
        end

        // run drop in phase 1 with DIV=3: {busy, start, done, ch, phase}
        apply_reset();
        for (int t = 0; t < 13; t++) begin
            exp_v[5] = (t < 12);
            exp_v[4] = (t == 0);
            exp_v[3] = (t == 11);
            exp_v[2] = (t < 6);
            exp_v[1:0] = (t < 12) ? 2'(t / 3) : 2'd0;
            exp_q.push_back(exp_v);
        end
        run = 1'b1;
        for (int t = 0; t < 13; t++) begin
            tick();
            exp_v = exp_q.pop_front();
            check($sformatf("div3 t%0d", t), {busy_b, start_b, done_b, ch_b, phase_b}, exp_v);
            if (t == 3) run = 1'b0;
        end

        // stall in phase 2 for 5 clocks, and one clock in phase 3
        apply_reset();
        legacy_windows();
        run = 1'b1;
        ph = 0;
        for (int t = 0; t < 15; t++) begin
            st = (t >= 3 && t <= 7) || (t == 13);
            stall = st;
            tick();
            if (t > 0 && !(STALL_ON && st)) ph = (ph + 1) % 4;
            check($sformatf("stall t%0d phase", t), phase_a, ph);
            check($sformatf("stall t%0d ch_out", t), ch_a, legacy_ch[ph]);
            check($sformatf("stall t%0d cycle_done", t), done_a, (ph == 3) && !(STALL_ON && st));
        end
        stall = 1'b0;

        // window edge cases and a mid-cycle window change
        apply_reset();
        rise_a = {2'd2, 2'd3};
        fall_a = {2'd2, 2'd1};
        rise_c = 3'd7;
        fall_c = 3'd2;
        old_w = 4'b1001;
        new_w = 4'b0110;
        run = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            ch0_pat = (t < 4) ? old_w : new_w;
            check($sformatf("win t%0d phase", t), phase_a, t % 4);
            check($sformatf("win t%0d ch_out", t), ch_a, {1'b0, ch0_pat[t % 4]});
            check($sformatf("win np6 t%0d phase", t), phase_c, t % 6);
            check($sformatf("win np6 t%0d ch_out", t), ch_c, 0);
            if (t == 1) begin
                rise_a = {2'd2, 2'd1};
                fall_a = {2'd2, 2'd3};
            end
        end

        // reset in phase 2 while running, then restart
        apply_reset();
        legacy_windows();
        run = 1'b1;
        tick();
        tick();
        tick();
        check("rst pre phase", phase_a, 2);
        reset = 1'b1;
        tick();
        check("rst phase", phase_a, 0);
        check("rst ch_out", ch_a, 0);
        check("rst busy", busy_a, 0);
        check("rst cycle_start", start_a, 0);
        tick();
        check("rst hold busy", busy_a, 0);
        reset = 1'b0;
        tick();
        check("restart phase", phase_a, 0);
        check("restart cycle_start", start_a, 1);
        check("restart busy", busy_a, 1);
        check("restart ch_out", ch_a, 2'b01);
        run = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
